// File: rtl/note_highway_engine.sv
`default_nettype none
// ============================================================================
// Module   : note_highway_engine
// Brief    : DEPTH x NUM_LANES note grid shifted once per beat; streams erase
//            and redraw pixels and exposes the strike row. Optional miss
//            counter enabled by defining NHE_MISS_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module note_highway_engine #(
    parameter int NUM_LANES  = 5,
    parameter int DEPTH      = 8,
    parameter int NOTE_W     = 8,
    parameter int NOTE_H     = 6,
    parameter int LANE_X0    = 100,
    parameter int LANE_PITCH = 24,
    parameter int ROW_Y0     = 20,
    parameter int ROW_PITCH  = 24,
    parameter int COLOUR_W   = 9,
    parameter logic [COLOUR_W-1:0]           BG_COLOUR    = '0,
    parameter logic [NUM_LANES*COLOUR_W-1:0] LANE_COLOURS = {5{9'h1FF}}
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 beat,
    input  logic                 pause,
    input  logic                 stop,
    input  logic [NUM_LANES-1:0] new_notes,
    input  logic [NUM_LANES-1:0] hit_notes,
    output logic [NUM_LANES-1:0] notes_to_play,
    output logic [8:0]           x,
    output logic [7:0]           y,
    output logic [COLOUR_W-1:0]  colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 beat_overrun
`ifdef NHE_MISS_COUNT_EN
    ,
    output logic [15:0]          missed_count
`endif
);

    localparam int c_row_w  = (DEPTH > 1)     ? $clog2(DEPTH)     : 1;
    localparam int c_lane_w = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int c_px_w   = (NOTE_W > 1)    ? $clog2(NOTE_W)    : 1;
    localparam int c_py_w   = (NOTE_H > 1)    ? $clog2(NOTE_H)    : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAW  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    state_t                          r_state;
    logic [DEPTH-1:0][NUM_LANES-1:0] r_grid;
    logic [NUM_LANES-1:0]            r_hit_mask;
    logic                            r_pending;
    logic                            r_clear;
    logic [c_row_w-1:0]              r_row;
    logic [c_lane_w-1:0]             r_lane;
    logic [c_px_w-1:0]               r_px;
    logic [c_py_w-1:0]               r_py;

    logic                            w_cell;
    logic                            w_px_last;
    logic                            w_pix_last;
    logic                            w_cell_done;
    logic                            w_walk_last;
    logic                            w_beat_live;
    logic [8:0]                      w_x;
    logic [7:0]                      w_y;
    logic [COLOUR_W-1:0]             w_lane_colour;

    assign w_cell        = r_grid[r_row][r_lane];
    assign w_px_last     = (32'(r_px) == NOTE_W - 1);
    assign w_pix_last    = w_px_last && (32'(r_py) == NOTE_H - 1);
    assign w_cell_done   = !w_cell || w_pix_last;
    assign w_walk_last   = w_cell_done && (32'(r_row) == DEPTH - 1)
                           && (32'(r_lane) == NUM_LANES - 1);
    assign w_beat_live   = beat && !pause;
    assign w_x           = 9'(LANE_X0 + 32'(r_lane) * LANE_PITCH + 32'(r_px));
    assign w_y           = 8'(ROW_Y0 + 32'(r_row) * ROW_PITCH + 32'(r_py));
    assign w_lane_colour = LANE_COLOURS[32'(r_lane) * COLOUR_W +: COLOUR_W];
    assign busy          = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_grid        <= '0;
            r_hit_mask    <= '0;
            r_pending     <= 1'b0;
            r_clear       <= 1'b0;
            r_row         <= '0;
            r_lane        <= '0;
            r_px          <= '0;
            r_py          <= '0;
            notes_to_play <= '0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
            plot          <= 1'b0;
            beat_overrun  <= 1'b0;
        end else begin
            notes_to_play <= r_grid[DEPTH-1] & ~r_hit_mask;
            r_hit_mask    <= r_hit_mask | hit_notes;

            // A beat that arrives mid-pass is remembered once; a second one is lost.
            if (w_beat_live && (r_state != ST_IDLE)) begin
                if (r_pending) begin
                    beat_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    if (stop) begin
                        r_state <= ST_ERASE;
                        r_clear <= 1'b1;
                    end else if ((beat || r_pending) && !pause) begin
                        r_state   <= ST_ERASE;
                        r_clear   <= 1'b0;
                        r_pending <= beat && r_pending;
                    end
                end

                ST_ERASE, ST_DRAW: begin
                    if (pause) begin
                        plot <= 1'b0;
                    end else begin
                        plot <= w_cell;
                        if (w_cell) begin
                            x      <= w_x;
                            y      <= w_y;
                            colour <= (r_state == ST_ERASE) ? BG_COLOUR : w_lane_colour;
                        end

                        // Row-major cell walk; a set cell scans its box px-inner.
                        if (!w_cell_done) begin
                            if (w_px_last) begin
                                r_px <= '0;
                                r_py <= r_py + 1'b1;
                            end else begin
                                r_px <= r_px + 1'b1;
                            end
                        end else begin
                            r_px <= '0;
                            r_py <= '0;
                            if (32'(r_lane) == NUM_LANES - 1) begin
                                r_lane <= '0;
                                r_row  <= (32'(r_row) == DEPTH - 1) ? '0 : r_row + 1'b1;
                            end else begin
                                r_lane <= r_lane + 1'b1;
                            end
                        end

                        if (w_walk_last) begin
                            if (r_state == ST_DRAW) begin
                                r_state <= ST_IDLE;
                            end else if (r_clear) begin
                                r_state   <= ST_CLEAR;
                                r_pending <= 1'b0;
                            end else begin
                                r_state <= ST_SHIFT;
                            end
                        end
                    end
                end

                ST_SHIFT: begin
                    plot       <= 1'b0;
                    r_grid     <= {r_grid[DEPTH-2:0], new_notes};
                    r_hit_mask <= '0;
                    r_state    <= ST_DRAW;
                end

                ST_CLEAR: begin
                    plot       <= 1'b0;
                    r_grid     <= '0;
                    r_hit_mask <= '0;
                    r_clear    <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    plot    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef NHE_MISS_COUNT_EN
    logic [16:0] w_miss_sum;

    always_comb begin
        w_miss_sum = {1'b0, missed_count};
        for (int i = 0; i < NUM_LANES; i++) begin
            w_miss_sum = w_miss_sum + 17'(r_grid[DEPTH-1][i] & ~r_hit_mask[i]);
        end
    end

    // Unhit strike-row notes become misses only when a real shift discards them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            missed_count <= '0;
        end else if (r_state == ST_SHIFT) begin
            missed_count <= w_miss_sum[16] ? 16'hFFFF : w_miss_sum[15:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_note_highway_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_highway_engine
// Brief    : Directed bench for note_highway_engine with a pass-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_note_highway_engine;

    localparam int NL = 5;
    localparam int D  = 8;
    localparam int NW = 8;
    localparam int NH = 6;
    localparam int CW = 9;
    localparam logic [NL*CW-1:0] LCOLS = {9'h111, 9'h0F0, 9'h0AA, 9'h155, 9'h1FF};
    localparam logic [CW-1:0]    BG    = 9'h000;

    localparam int P_IDLE  = 0;
    localparam int P_ERASE = 1;
    localparam int P_SHIFT = 2;
    localparam int P_DRAW  = 3;
    localparam int P_CLEAR = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          beat = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic [NL-1:0] new_notes = '0;
    logic [NL-1:0] hit_notes = '0;
    logic [NL-1:0] notes_to_play;
    logic [8:0]    x;
    logic [7:0]    y;
    logic [CW-1:0] colour;
    logic          plot;
    logic          busy;
    logic          beat_overrun;
`ifdef NHE_MISS_COUNT_EN
    logic [15:0]   missed_count;
`endif

    note_highway_engine #(
        .NUM_LANES(NL), .DEPTH(D), .NOTE_W(NW), .NOTE_H(NH),
        .LANE_X0(100), .LANE_PITCH(24), .ROW_Y0(20), .ROW_PITCH(24),
        .COLOUR_W(CW), .BG_COLOUR(BG), .LANE_COLOURS(LCOLS)
    ) dut (
        .clk(clk), .resetn(resetn), .beat(beat), .pause(pause), .stop(stop),
        .new_notes(new_notes), .hit_notes(hit_notes),
        .notes_to_play(notes_to_play), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .beat_overrun(beat_overrun)
`ifdef NHE_MISS_COUNT_EN
        , .missed_count(missed_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- pass-level reference model ----------------
    typedef struct packed {
        logic [8:0]    x;
        logic [7:0]    y;
        logic [CW-1:0] c;
    } pix_t;

    bit [NL-1:0] m_grid [D];
    bit [NL-1:0] m_mask, m_ntp;
    bit          m_pend, m_ovr, m_clear;
    int          m_phase, m_left, m_miss, m_base;
    pix_t        exp_q[$];

    function automatic int pass_len();
        int n = 0;
        for (int r = 0; r < D; r++) n += $countones(m_grid[r]);
        return NL * D + n * (NW * NH - 1);
    endfunction

    task automatic push_pixels(input bit draw);
        for (int r = 0; r < D; r++)
            for (int l = 0; l < NL; l++)
                if (m_grid[r][l])
                    for (int py = 0; py < NH; py++)
                        for (int px = 0; px < NW; px++) begin
                            pix_t p;
                            p.x = 9'(100 + l * 24 + px);
                            p.y = 8'(20 + r * 24 + py);
                            p.c = draw ? LCOLS[l*CW +: CW] : BG;
                            exp_q.push_back(p);
                        end
    endtask

    always @(posedge clk) begin
        bit bl;
        if (!resetn) begin
            for (int r = 0; r < D; r++) m_grid[r] = '0;
            m_mask = '0; m_ntp = '0; m_pend = 0; m_ovr = 0; m_clear = 0;
            m_phase = P_IDLE; m_left = 0; m_miss = 0;
            m_base = exp_q.size();
        end else begin
            bl    = beat && !pause;
            m_ntp = m_grid[D-1] & ~m_mask;
            if (m_phase != P_SHIFT && m_phase != P_CLEAR) m_mask |= hit_notes;
            if (bl && m_phase != P_IDLE) begin
                if (m_pend) m_ovr = 1; else m_pend = 1;
            end
            case (m_phase)
                P_IDLE: begin
                    if (stop || ((beat || m_pend) && !pause)) begin
                        if (!stop) m_pend = beat && m_pend;
                        m_clear = stop;
                        m_phase = P_ERASE;
                        m_left  = pass_len();
                        push_pixels(0);
                    end
                end
                P_ERASE: if (!pause) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_clear) begin m_phase = P_CLEAR; m_pend = 0; end
                        else m_phase = P_SHIFT;
                    end
                end
                P_SHIFT: begin
                    m_miss += $countones(m_grid[D-1] & ~m_mask);
                    if (m_miss > 65535) m_miss = 65535;
                    for (int r = D - 1; r > 0; r--) m_grid[r] = m_grid[r-1];
                    m_grid[0] = new_notes;
                    m_mask  = '0;
                    m_phase = P_DRAW;
                    m_left  = pass_len();
                    push_pixels(1);
                end
                P_DRAW: if (!pause) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_IDLE;
                end
                default: begin
                    for (int r = 0; r < D; r++) m_grid[r] = '0;
                    m_mask = '0; m_clear = 0; m_phase = P_IDLE;
                end
            endcase
        end
    end

    // ---------------- checking and stimulus ----------------
    int         n_tests = 0, n_fail = 0;
    int         rd = 0, plot_cnt = 0, busy_cnt = 0;
    logic [8:0] last_x;
    logic [7:0] last_y;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        pix_t p;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("notes_to_play", 32'(notes_to_play), 32'(m_ntp));
        chk("beat_overrun", 32'(beat_overrun), 32'(m_ovr));
`ifdef NHE_MISS_COUNT_EN
        chk("missed_count", 32'(missed_count), 32'(m_miss));
`endif
        if (rd < m_base) rd = m_base;
        if (busy === 1'b1) busy_cnt++;
        if (plot === 1'b1) begin
            plot_cnt++;
            if (rd >= exp_q.size()) begin
                chk("plot_unexpected", 32'(plot), 32'd0);
            end else begin
                p = exp_q[rd];
                rd++;
                chk("pix_x", 32'(x), 32'(p.x));
                chk("pix_y", 32'(y), 32'(p.y));
                chk("pix_colour", 32'(colour), 32'(p.c));
                last_x = p.x;
                last_y = p.y;
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        int quiet = 0;
        for (int i = 0; i < limit && quiet < 2; i++) begin
            cyc();
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
        end
        if (quiet < 2) chk("wait_idle_timeout", 32'(busy), 32'd0);
        chk("pixels_outstanding", 32'(exp_q.size() - rd), 32'd0);
    endtask

    task automatic wait_plot(input int limit);
        for (int i = 0; i < limit && plot !== 1'b1; i++) cyc();
        if (plot !== 1'b1) chk("wait_plot_timeout", 32'(plot), 32'd1);
    endtask

    task automatic pulse_beat(input logic [NL-1:0] notes);
        new_notes = notes;
        beat = 1'b1;
        cyc();
        beat = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_colour"}, 32'(colour), 32'd0);
        chk({tag, "_plot"}, 32'(plot), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(beat_overrun), 32'd0);
        chk({tag, "_ntp"}, 32'(notes_to_play), 32'd0);
`ifdef NHE_MISS_COUNT_EN
        chk({tag, "_missed"}, 32'(missed_count), 32'd0);
`endif
    endtask

    initial begin
        int b0, p0;
        resetn = 1'b0;
        cyc(); cyc();
        check_reset_outputs("reset");
        resetn = 1'b1;
        cyc();

        // single note enters row 0
        b0 = busy_cnt; p0 = plot_cnt;
        pulse_beat(5'b00001);
        wait_idle(2000);
        chk("t2_busy_cycles", 32'(busy_cnt - b0), 32'd128);
        chk("t2_plots", 32'(plot_cnt - p0), 32'd48);
        chk("t2_x_end", 32'(x), 32'd107);
        chk("t2_y_end", 32'(y), 32'd25);
        chk("t2_colour", 32'(colour), 32'h1FF);

        // walk it down to the strike row, then past it
        for (int i = 0; i < 7; i++) begin
            pulse_beat(5'b00000);
            wait_idle(2000);
        end
        chk("t3_strike_ntp", 32'(notes_to_play), 32'b00001);
        chk("t3_y_end", 32'(y), 32'd193);
        chk("t3_x_end", 32'(x), 32'd107);
        pulse_beat(5'b00001);
        wait_idle(2000);
        chk("t3_ntp_after", 32'(notes_to_play), 32'd0);
`ifdef NHE_MISS_COUNT_EN
        chk("t3_missed", 32'(missed_count), 32'd1);
`endif

        // hit the strike-row note while idle
        for (int i = 0; i < 7; i++) begin
            pulse_beat(5'b00000);
            wait_idle(2000);
        end
        chk("t4_strike_ntp", 32'(notes_to_play), 32'b00001);
        hit_notes = 5'b00001;
        cyc();
        hit_notes = '0;
        cyc();
        chk("t4_ntp_hit", 32'(notes_to_play), 32'd0);
        pulse_beat(5'b10101);
        wait_idle(2000);
`ifdef NHE_MISS_COUNT_EN
        chk("t4_missed_kept", 32'(missed_count), 32'd1);
`endif

        // beats while busy: one pends, the next overruns
        pulse_beat(5'b01010);
        repeat (5) cyc();
        beat = 1'b1; cyc(); beat = 1'b0;
        repeat (5) cyc();
        chk("t5_no_overrun_yet", 32'(beat_overrun), 32'd0);
        beat = 1'b1; cyc(); beat = 1'b0;
        cyc();
        chk("t5_overrun", 32'(beat_overrun), 32'd1);
        wait_idle(4000);
        chk("t5_overrun_sticky", 32'(beat_overrun), 32'd1);

        // stop clears three rows (7 notes) without a DRAW
        b0 = busy_cnt; p0 = plot_cnt;
        stop = 1'b1; cyc(); stop = 1'b0;
        wait_idle(2000);
        chk("t5_stop_plots", 32'(plot_cnt - p0), 32'd336);
        chk("t5_stop_busy", 32'(busy_cnt - b0), 32'd370);
        chk("t5_stop_colour", 32'(colour), 32'(BG));

        // pause mid-DRAW
        b0 = busy_cnt; p0 = plot_cnt;
        pulse_beat(5'b00001);
        wait_plot(200);
        repeat (5) cyc();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t6_pause_plot", 32'(plot), 32'd0);
            chk("t6_pause_x", 32'(x), 32'(last_x));
            chk("t6_pause_y", 32'(y), 32'(last_y));
        end
        pause = 1'b0;
        wait_idle(2000);
        chk("t6_plots", 32'(plot_cnt - p0), 32'd48);
        chk("t6_busy", 32'(busy_cnt - b0), 32'd138);

        b0 = busy_cnt; p0 = plot_cnt;
        stop = 1'b1; cyc(); stop = 1'b0;
        wait_idle(2000);
        chk("t6_stop_plots", 32'(plot_cnt - p0), 32'd48);
        chk("t6_stop_busy", 32'(busy_cnt - b0), 32'd88);
        chk("t6_stop_ntp", 32'(notes_to_play), 32'd0);

        // reset held mid-DRAW aborts the pass
        pulse_beat(5'b00011);
        wait_plot(200);
        repeat (3) cyc();
        resetn = 1'b0;
        cyc(); cyc();
        check_reset_outputs("t1_reset");
        resetn = 1'b1;
        b0 = busy_cnt; p0 = plot_cnt;
        pulse_beat(5'b00100);
        wait_idle(2000);
        chk("t1_plots", 32'(plot_cnt - p0), 32'd48);
        chk("t1_busy", 32'(busy_cnt - b0), 32'd128);
        chk("t1_x_end", 32'(x), 32'd155);
        chk("t1_colour", 32'(colour), 32'h0AA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
